// File: rtl/fifo_rd_stream_pkg.sv
// Shared types, default widths and helpers for the fifo_rd_stream drain stage.
package fifo_rd_stream_pkg;

  localparam int unsigned DEF_FIFO_WIDTH = 8;
  localparam int unsigned DEF_RD_LATENCY = 1;
  localparam int unsigned DEF_BUF_DEPTH  = 4;
  localparam int unsigned STAT_W         = 16;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // ceil(log2(value)), never less than 1 so single-entry counters still get a bit
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_buf.sv
// Small register FIFO that absorbs returning read beats ahead of the stream output.
module fifo_rd_stream_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_FIFO_WIDTH,
  parameter int unsigned DEPTH = DEF_BUF_DEPTH,
  localparam int unsigned PTR_W = clog2_min1(DEPTH),
  localparam int unsigned OCC_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [OCC_W-1:0] occupancy
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // Clear wins over push/pop; pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a fixed-latency synchronous fifo into a valid/ready stream, with flush.
// Optional transfer/drop counters when FIFO_RD_STREAM_STATS_EN is defined.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int unsigned RD_LATENCY = DEF_RD_LATENCY,
  parameter int unsigned BUF_DEPTH  = DEF_BUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  flush,
  output logic                  flush_done
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [STAT_W-1:0]     beat_count,
  output logic [STAT_W-1:0]     drop_count
`endif
);

  localparam int unsigned PTR_W = clog2_min1(BUF_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned CNT_W = clog2_min1(RD_LATENCY + 1);
  localparam int unsigned SUM_W = OCC_W + 1;

  state_t                 state;
  state_t                 next_state;
  logic [RD_LATENCY-1:0]  inflight;
  logic [CNT_W-1:0]       inflight_cnt;
  logic [OCC_W-1:0]       occupancy;
  logic [SUM_W-1:0]       fill_sum;
  logic                   arrive;
  logic                   xfer;
  logic                   buf_clear;
  logic                   buf_push;
  logic                   done_set;

  assign arrive   = inflight[RD_LATENCY-1];
  assign xfer     = m_valid && m_ready;
  assign fill_sum = SUM_W'(occupancy) + SUM_W'(inflight_cnt);

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      inflight_cnt = inflight_cnt + CNT_W'(inflight[i]);
    end
  end

  // Pop decision sees only registered occupancy/in-flight plus fifo_empty, never m_ready
  always_comb begin
    next_state = state;
    fifo_rd_en = 1'b0;
    m_valid    = 1'b0;
    buf_clear  = 1'b0;
    buf_push   = 1'b0;
    done_set   = 1'b0;
    case (state)
      RUN: begin
        fifo_rd_en = !fifo_empty && (fill_sum < SUM_W'(BUF_DEPTH));
        m_valid    = (occupancy != '0);
        buf_push   = arrive;
        if (flush) begin
          next_state = FLUSH;
          buf_clear  = 1'b1;
        end
      end
      FLUSH: begin
        if (inflight_cnt == '0) begin
          done_set   = 1'b1;
          next_state = flush ? FLUSH : RUN;
        end
      end
      default: next_state = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= RUN;
      inflight   <= '0;
      flush_done <= 1'b0;
    end else begin
      state      <= next_state;
      inflight   <= (inflight << 1) | RD_LATENCY'(fifo_rd_en);
      flush_done <= done_set;
    end
  end

  fifo_rd_stream_buf #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rstN      (rstN),
    .clear     (buf_clear),
    .push      (buf_push),
    .push_data (fifo_data_out),
    .pop       (xfer),
    .head      (m_data),
    .occupancy (occupancy)
  );

`ifdef FIFO_RD_STREAM_STATS_EN
  localparam int unsigned DROP_W = OCC_W + 1;

  logic [DROP_W-1:0] drop_inc;
  logic [STAT_W:0]   drop_sum;

  // Beats lost to a flush: what the buffer held (minus a same-cycle transfer) plus late arrivals
  always_comb begin
    drop_inc = '0;
    if (state == RUN && flush) begin
      drop_inc = DROP_W'(occupancy) - DROP_W'(xfer) + DROP_W'(arrive);
    end else if (state == FLUSH) begin
      drop_inc = DROP_W'(arrive);
    end
  end

  assign drop_sum = {1'b0, drop_count} + (STAT_W + 1)'(drop_inc);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      beat_count <= '0;
      drop_count <= '0;
    end else begin
      if (xfer && (beat_count != '1)) beat_count <= beat_count + STAT_W'(1);
      drop_count <= drop_sum[STAT_W] ? '1 : drop_sum[STAT_W-1:0];
    end
  end
`endif

endmodule
